// File: rtl/dp_seq_core_if.sv
// Micro-op handshake bundle for dp_seq_core: valid/ready plus the decoded op fields.
interface dp_seq_core_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            op_valid;
  logic            op_ready;
  logic [3:0]      op_alu;
  logic [AW-1:0]   op_rs0;
  logic [AW-1:0]   op_rs1;
  logic [AW-1:0]   op_rd;
  logic [XLEN-1:0] op_imm;
  logic            op_use_imm;
  logic            op_jump;
  logic            op_wr_en;

  modport master (
    output op_valid, op_alu, op_rs0, op_rs1, op_rd, op_imm, op_use_imm, op_jump, op_wr_en,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_alu, op_rs0, op_rs1, op_rd, op_imm, op_use_imm, op_jump, op_wr_en,
    output op_ready
  );
endinterface

// File: rtl/dp_seq_core.sv
// Register file + PC + ALU sequenced IDLE->RD->EX->WB, one micro-op per four cycles.
// Optional retire counter output enabled by defining DP_RETIRE_CNT_EN.
module dp_seq_core #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  dp_seq_core_if.slave             op,
  output logic [XLEN-1:0]          pc,
  output logic [XLEN-1:0]          result,
  output logic                     done,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_data
`ifdef DP_RETIRE_CNT_EN
  ,
  output logic [31:0]              retired
`endif
);
  localparam int AW  = $clog2(NREGS);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [3:0]      alu_q;
  logic [AW-1:0]   rs0_q, rs1_q, rd_q;
  logic [XLEN-1:0] imm_q, a_q, b_q, result_q, pc_q;
  logic            use_imm_q, jump_q, wr_en_q, done_q;
  logic            accept_s;
  logic [XLEN-1:0] pc_next_s;

  function automatic logic [XLEN-1:0] rf_read(input logic [AW-1:0] addr,
                                              input logic [XLEN-1:0] file [NREGS]);
    return (addr == '0) ? '0 : file[addr];
  endfunction

  function automatic logic [XLEN-1:0] alu(input logic [3:0] code,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (code)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return $unsigned($signed(a) >>> sh);
      4'd8:    return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9:    return {{(XLEN-1){1'b0}}, (a < b)};
      4'd10:   return b;
      default: return '0;
    endcase
  endfunction

  assign accept_s  = (state_q == S_IDLE) && op.op_valid;
  assign pc_next_s = pc_q + XLEN'(PC_STEP);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept_s ? S_RD : S_IDLE;
      S_RD:    state_d = S_EX;
      S_EX:    state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    op.op_ready = 1'b0;
    if (state_q == S_IDLE) op.op_ready = 1'b1;
    else                   op.op_ready = 1'b0;
  end

  // Op capture, operand fetch, execute and PC/retire bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q     <= 4'd0;
      rs0_q     <= '0;
      rs1_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      jump_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      pc_q      <= PC_RESET;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == S_WB);
      if (accept_s) begin
        alu_q     <= op.op_alu;
        rs0_q     <= op.op_rs0;
        rs1_q     <= op.op_rs1;
        rd_q      <= op.op_rd;
        imm_q     <= op.op_imm;
        use_imm_q <= op.op_use_imm;
        jump_q    <= op.op_jump;
        wr_en_q   <= op.op_wr_en;
      end
      if (state_q == S_RD) begin
        a_q <= rf_read(rs0_q, regs_q);
        b_q <= use_imm_q ? imm_q : rf_read(rs1_q, regs_q);
      end
      if (state_q == S_EX) result_q <= alu(alu_q, a_q, b_q);
      // Jump targets are forced even; the link value uses the PC before this update
      if (state_q == S_WB) pc_q <= jump_q ? {result_q[XLEN-1:1], 1'b0} : pc_next_s;
    end
  end

  // Register file write-back; entry 0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if ((state_q == S_WB) && wr_en_q && (rd_q != '0)) begin
      regs_q[rd_q] <= jump_q ? pc_next_s : result_q;
    end
  end

`ifdef DP_RETIRE_CNT_EN
  logic [31:0] retired_q;

  // Retire counter, one count per write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   retired_q <= 32'd0;
    else if (state_q == S_WB)  retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`endif

  assign pc       = pc_q;
  assign result   = result_q;
  assign done     = done_q;
  assign dbg_data = rf_read(dbg_addr, regs_q);
endmodule

// File: tb/tb_dp_seq_core.sv
// Self-checking bench for dp_seq_core: directed plan steps then random ops vs. a reference model.
module tb_dp_seq_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, result, dbg_data;
  logic        done;
  logic [4:0]  dbg_addr;
`ifdef DP_RETIRE_CNT_EN
  logic [31:0] retired;
  int unsigned m_ret;
`endif

  int total = 0;
  int fails = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] m_res;

  dp_seq_core_if #(.XLEN(32), .NREGS(32)) bus ();

  dp_seq_core #(.XLEN(32), .NREGS(32), .PC_RESET(32'd0), .PC_STEP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (bus),
    .pc       (pc),
    .result   (result),
    .done     (done),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`ifdef DP_RETIRE_CNT_EN
    ,
    .retired  (retired)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (code)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return $unsigned($signed(a) >>> sh);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc  = 32'd0;
    m_res = 32'd0;
`ifdef DP_RETIRE_CNT_EN
    m_ret = 0;
`endif
  endtask

  task automatic junk_inputs();
    bus.op_valid   = 1'($urandom_range(0, 1));
    bus.op_alu     = 4'($urandom);
    bus.op_rs0     = 5'($urandom);
    bus.op_rs1     = 5'($urandom);
    bus.op_rd      = 5'($urandom);
    bus.op_imm     = $urandom;
    bus.op_use_imm = 1'($urandom_range(0, 1));
    bus.op_jump    = 1'($urandom_range(0, 1));
    bus.op_wr_en   = 1'($urandom_range(0, 1));
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Issue one op, check the retire timing and the architectural outcome against the model.
  task automatic do_op(input string tag, input logic [3:0] alu, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [4:0] rd, input logic [31:0] imm,
                       input logic ui, input logic jmp, input logic we);
    logic [31:0] a, b, link, v;
    logic [4:0]  ra;
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, bus.op_ready}, 32'd1);
    bus.op_valid = 1'b1; bus.op_alu = alu; bus.op_rs0 = rs0; bus.op_rs1 = rs1;
    bus.op_rd = rd; bus.op_imm = imm; bus.op_use_imm = ui; bus.op_jump = jmp; bus.op_wr_en = we;
    a = m_regs[rs0];
    b = ui ? imm : m_regs[rs1];
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk({tag, ".done_low"}, {31'd0, done}, 32'd0);
      chk({tag, ".busy"}, {31'd0, bus.op_ready}, 32'd0);
      junk_inputs();
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".ready_ret"}, {31'd0, bus.op_ready}, 32'd1);
    m_res = ref_alu(alu, a, b);
    link  = m_pc + 32'd4;
    if (we && rd != 5'd0) m_regs[rd] = jmp ? link : m_res;
    m_pc = jmp ? (m_res & 32'hFFFF_FFFE) : link;
`ifdef DP_RETIRE_CNT_EN
    m_ret++;
    chk({tag, ".retired"}, retired, m_ret);
`endif
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".pc"}, pc, m_pc);
    read_reg(rd, v);
    chk({tag, ".rd"}, v, m_regs[rd]);
    ra = 5'($urandom);
    read_reg(ra, v);
    chk({tag, ".rnd_reg"}, v, m_regs[ra]);
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    dbg_addr = 5'd0;
    bus.op_valid = 1'b0; bus.op_alu = 4'd0; bus.op_rs0 = 5'd0; bus.op_rs1 = 5'd0;
    bus.op_rd = 5'd0; bus.op_imm = 32'd0; bus.op_use_imm = 1'b0; bus.op_jump = 1'b0;
    bus.op_wr_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.pc", pc, 32'd0);
    chk("rst.ready", {31'd0, bus.op_ready}, 32'd1);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.result", result, 32'd0);
    for (int i = 0; i < 32; i++) begin
      read_reg(5'(i), v);
      chk("rst.dbg", v, 32'd0);
    end

    do_op("li", 4'd10, 5'd0, 5'd0, 5'd3, 32'h0000_0005, 1'b1, 1'b0, 1'b1);
    read_reg(5'd3, v);
    chk("li.x3", v, 32'd5);
    chk("li.pc", pc, 32'd4);
    chk("li.res", result, 32'd5);

    do_op("li_x1", 4'd10, 5'd0, 5'd0, 5'd1, 32'd7, 1'b1, 1'b0, 1'b1);
    do_op("li_x2", 4'd10, 5'd0, 5'd0, 5'd2, 32'hFFFF_FFF9, 1'b1, 1'b0, 1'b1);
    do_op("sub", 4'd1, 5'd1, 5'd2, 5'd4, 32'd0, 1'b0, 1'b0, 1'b1);
    read_reg(5'd4, v);
    chk("sub.x4", v, 32'h0000_000E);
    chk("sub.pc", pc, 32'h10);

    do_op("jal", 4'd0, 5'd0, 5'd0, 5'd1, 32'h41, 1'b1, 1'b1, 1'b1);
    chk("jal.pc", pc, 32'h40);
    read_reg(5'd1, v);
    chk("jal.x1", v, 32'h14);

    do_op("li_x1b", 4'd10, 5'd0, 5'd0, 5'd1, 32'd7, 1'b1, 1'b0, 1'b1);
    do_op("slt", 4'd8, 5'd1, 5'd2, 5'd6, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("slt.res", result, 32'd0);
    do_op("sltu", 4'd9, 5'd1, 5'd2, 5'd7, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("sltu.res", result, 32'd1);

    do_op("x0", 4'd10, 5'd0, 5'd0, 5'd0, 32'h1234, 1'b1, 1'b0, 1'b1);
    read_reg(5'd0, v);
    chk("x0.dbg", v, 32'd0);

`ifdef DP_RETIRE_CNT_EN
    chk("ret.pre", retired, m_ret);
`endif

    // Reset while the op sits in EX: nothing may retire or be written.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_alu = 4'd10; bus.op_rs0 = 5'd0; bus.op_rs1 = 5'd0;
    bus.op_rd = 5'd5; bus.op_imm = 32'h55; bus.op_use_imm = 1'b1; bus.op_jump = 1'b0;
    bus.op_wr_en = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("midrst.no_done", {31'd0, done}, 32'd0);
    end
    chk("midrst.pc", pc, 32'd0);
    chk("midrst.ready", {31'd0, bus.op_ready}, 32'd1);
    read_reg(5'd5, v);
    chk("midrst.x5", v, 32'd0);
`ifdef DP_RETIRE_CNT_EN
    chk("midrst.retired", retired, 32'd0);
`endif

    for (int n = 0; n < 3; n++)
      do_op("ret3", 4'd0, 5'd0, 5'd0, 5'(n + 1), 32'(n + 100), 1'b1, 1'b0, 1'b1);
`ifdef DP_RETIRE_CNT_EN
    chk("ret3.count", retired, 32'd3);
`endif

    for (int n = 0; n < 60; n++) begin
      logic j;
      j = ($urandom_range(0, 7) == 0);
      do_op("rand", 4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            1'($urandom_range(0, 1)), j, ($urandom_range(0, 5) != 0));
    end

    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("end_rst.pc", pc, 32'd0);
`ifdef DP_RETIRE_CNT_EN
    chk("end_rst.retired", retired, 32'd0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/dp_seq_core.md
Name: dp_seq_core

Overview:
- Parametrised successor to the single-cycle test datapath: one block containing a register file, PC register and ALU, sequenced by a 4-state FSM.
- Micro-ops arrive on a valid/ready handshake and execute as read -> execute -> write-back.
- Supports jump-and-link, an immediate operand and a debug read port.
- Sits between the test/decoder front end and the future fetch unit.

Parameters:
- XLEN, 32, datapath, register and PC width.
- NREGS, 32, number of architectural registers (power of two, >= 2); register 0 is hardwired to zero.
- PC_RESET, 0, PC value after reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  micro-op present.
- op_ready  out  1  block can accept a micro-op.
- op_alu  in  4  ALU operation code.
- op_rs0  in  log2(NREGS)  source A register.
- op_rs1  in  log2(NREGS)  source B register.
- op_rd  in  log2(NREGS)  destination register.
- op_imm  in  XLEN  immediate.
- op_use_imm  in  1  B operand = op_imm instead of rs1.
- op_jump  in  1  jump: PC <= ALU result, rd <= old PC + PC_STEP.
- op_wr_en  in  1  write-back enable.
- pc  out  XLEN  current PC.
- result  out  XLEN  last ALU result.
- done  out  1  one-cycle retire pulse.
- dbg_addr  in  log2(NREGS)  debug read address.
- dbg_data  out  XLEN  combinational register read (0 for address 0).

Behaviour:
- Reset (async, any state):
  - FSM -> IDLE; pc=PC_RESET; result=0; done=0; all registers=0.
  - Any in-flight op is discarded; no write, no PC update.
- FSM states IDLE, RD, EX, WB:
  - IDLE: op_ready=1. op_valid&op_ready at an edge captures all op_* fields into internal latches and moves to RD. op_ready=0 in every other state.
  - RD: latch A=reg[rs0]; B=op_use_imm ? imm : reg[rs1]. -> EX.
  - EX: result<=ALU(A,B) -> WB.
  - WB:
    - Register write: if wr_en and rd!=0, reg[rd] <= (jump ? pc+PC_STEP : result), using pre-update pc.
    - PC update: pc <= jump ? {result[XLEN-1:1],1'b0} : pc+PC_STEP.
    - done<=1 for exactly the next cycle, then -> IDLE.
- Timing:
  - Accept at edge N; done high in the cycle after edge N+3.
  - op_ready returns high in the same cycle as done, so the next op may be accepted at edge N+4.
  - Maximum throughput: 1 op / 4 cycles.
- ALU codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 0/1), 9 SLTU, 10 PASSB.
  - 11-15 produce 0.
  - Shifts use B[log2(XLEN)-1:0].
  - All arithmetic wraps modulo 2^XLEN; pc+PC_STEP wraps likewise.
- Register rules:
  - Register 0 reads 0 in RD and on dbg_data; writes to it are dropped.
  - RD reads the registered file state, so a write in WB of op k is visible to op k+1's RD.
- op_* inputs are ignored outside IDLE; holding op_valid during a busy op has no effect.

Optional Feature:
- Macro DP_RETIRE_CNT_EN.
- Defined:
  - Adds output port retired [31:0], reset 0.
  - Increments by 1 on every WB edge (same edge that sets done); wraps at 2^32.
  - Unaffected by op contents.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: rst pulse mid-cycle, no ops.
  - Required: pc=0, op_ready=1, done=0, dbg_data=0 for every address.
- Load immediate:
  - Stimulus: op {alu=10, use_imm=1, imm=0x0000_0005, rd=3, wr_en=1}.
  - Required: done pulses 4 cycles after accept; dbg_addr=3 -> 5; pc=4; result=5.
- Dependent ops back-to-back:
  - Stimulus: x1=7 then x2=0xFFFF_FFF9 via immediate ops, then op {SUB, rs0=1, rs1=2, rd=4}.
  - Required: x4=0x0000_000E; SLT x1<x2 gives 0; SLTU x1<x2 gives 1.
- Jump-and-link:
  - Stimulus: pc=0x10; op {ADD, rs0=0, imm=0x41, use_imm=1, jump=1, rd=1, wr_en=1}.
  - Required: pc=0x40 (bit 0 cleared); x1=0x14.
- x0 and reset mid-op:
  - Stimulus 1: write 0x1234 to rd=0. Required: dbg_data[0]=0.
  - Stimulus 2: start a write to x5, assert rst while in EX. Required: x5=0, no done pulse, pc=PC_RESET, FSM IDLE.
- DP_RETIRE_CNT_EN:
  - Stimulus: retire 3 ops, then rst.
  - Required: retired=3 after the third done, then 0 after rst; compiles cleanly with the macro undefined.
